// File: rtl/bit_stream_gen.sv
// Serial bit-stream generator: parallel word in over valid/ready, MSB-first bits out,
// each bit held CLK_DIV clocks, GAP idle clocks between words.
module bit_stream_gen #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned GAP     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BitW = $clog2(WIDTH);
   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [BitW-1:0] BitLoad = BitW'(WIDTH - 1);
   localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);
   localparam logic [GapW-1:0] GapLoad = GapW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  shift_q;
   logic [BitW-1:0]   bit_cnt_q;
   logic [DivW-1:0]   div_q;
   logic [GapW-1:0]   gap_q;
   logic              ready_q;
   logic              bit_out_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   // bit_out_q tracks the next MSB so every output stays a plain flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         gap_q     <= '0;
         ready_q   <= 1'b1;
         bit_out_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (data_valid && ready_q) begin
                  state_q   <= StShift;
                  shift_q   <= data_in;
                  bit_cnt_q <= BitLoad;
                  div_q     <= DivLoad;
                  ready_q   <= 1'b0;
                  bit_out_q <= data_in[WIDTH-1];
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            StShift: begin
               if (div_q != '0) begin
                  div_q <= div_q - 1'b1;
               end else if (bit_cnt_q != '0) begin
                  shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                  bit_out_q <= shift_q[WIDTH-2];
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  div_q     <= DivLoad;
               end else begin
                  done_q    <= 1'b1;
                  valid_q   <= 1'b0;
                  bit_out_q <= 1'b0;
                  shift_q   <= '0;
                  if (GAP > 0) begin
                     state_q <= StGap;
                     gap_q   <= GapLoad;
                  end else begin
                     state_q <= StIdle;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            StGap: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               ready_q   <= 1'b1;
               bit_out_q <= 1'b0;
               valid_q   <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign data_ready = ready_q;
   assign bit_out    = bit_out_q;
   assign bit_valid  = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_bit_stream_gen.sv
// Scoreboard bench for bit_stream_gen: three instances (plain, divided, gapped) plus a
// small Moore "1011" detector fed from instance 0.
module tb_bit_stream_gen;

   localparam int SigReady   = 0;
   localparam int SigBusy    = 1;
   localparam int SigValid   = 2;
   localparam int SigBit     = 3;
   localparam int SigDone    = 4;
   localparam int SigDet     = 5;
   localparam int SigSpacing = 6;
   localparam int SigTimeout = 7;

   typedef struct {
      int at_cyc;
      int dut;
      int sig;
      int exp_v;
      int act_v;
   } chk_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       dv   [3];
   logic [7:0] din  [3];
   logic       rdy  [3];
   logic       bo   [3];
   logic       bv   [3];
   logic       bsy  [3];
   logic       dn   [3];

   int   cyc        = 0;
   int   n_chk      = 0;
   int   n_pass     = 0;
   bit   finish_req = 1'b0;
   int   div_of [3] = '{1, 3, 1};
   chk_t chk_q [$];
   logic exp_bits [3][$];
   int   exp_done [3][$];
   int   det_st = 0;
   logic det_out;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bit_stream_gen #(.WIDTH(8), .CLK_DIV(1), .GAP(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
      .bit_out(bo[0]), .bit_valid(bv[0]), .busy(bsy[0]), .done(dn[0]));
   bit_stream_gen #(.WIDTH(8), .CLK_DIV(3), .GAP(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
      .bit_out(bo[1]), .bit_valid(bv[1]), .busy(bsy[1]), .done(dn[1]));
   bit_stream_gen #(.WIDTH(8), .CLK_DIV(1), .GAP(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_valid(dv[2]), .data_ready(rdy[2]),
      .bit_out(bo[2]), .bit_valid(bv[2]), .busy(bsy[2]), .done(dn[2]));

   // Moore detector for "1011"; state = matched prefix length, state 4 = found.
   always @(posedge clk) begin
      if (!rst_n) det_st <= 0;
      else if (bv[0]) begin
         case (det_st)
            0:       det_st <= bo[0] ? 1 : 0;
            1:       det_st <= bo[0] ? 1 : 2;
            2:       det_st <= bo[0] ? 3 : 0;
            3:       det_st <= bo[0] ? 4 : 2;
            default: det_st <= bo[0] ? 1 : 2;
         endcase
      end
   end
   assign det_out = (det_st == 4);

   function automatic string sig_name(input int s);
      case (s)
         SigReady:   return "data_ready";
         SigBusy:    return "busy";
         SigValid:   return "bit_valid";
         SigBit:     return "bit_out";
         SigDone:    return "done";
         SigDet:     return "detector_out";
         SigSpacing: return "handshake_spacing";
         default:    return "handshake_timeout";
      endcase
   endfunction

   function automatic int sample(input int d, input int s);
      case (s)
         SigReady: return int'(rdy[d]);
         SigBusy:  return int'(bsy[d]);
         SigValid: return int'(bv[d]);
         SigBit:   return int'(bo[d]);
         SigDone:  return int'(dn[d]);
         SigDet:   return int'(det_out);
         default:  return -1;
      endcase
   endfunction

   task automatic check(input string name, input int d, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, d, cyc, act, exp);
   endtask

   // Monitor: pops bit/done expectations on DUT events, fires timed level checks.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (bv[i] === 1'b1) begin
            if (exp_bits[i].size() == 0) check("extra_bit", i, 1, 0);
            else begin
               logic eb;
               eb = exp_bits[i].pop_front();
               check("stream_bit", i, int'(bo[i]), int'(eb));
            end
         end
         if (dn[i] === 1'b1) begin
            if (exp_done[i].size() == 0) check("extra_done", i, cyc, -1);
            else begin
               int ed;
               ed = exp_done[i].pop_front();
               check("done_cycle", i, cyc, ed);
            end
         end
      end
      for (int j = chk_q.size() - 1; j >= 0; j--) begin
         if (chk_q[j].at_cyc == cyc) begin
            if (chk_q[j].sig >= SigSpacing)
               check(sig_name(chk_q[j].sig), chk_q[j].dut, chk_q[j].act_v, chk_q[j].exp_v);
            else
               check(sig_name(chk_q[j].sig), chk_q[j].dut,
                     sample(chk_q[j].dut, chk_q[j].sig), chk_q[j].exp_v);
            chk_q.delete(j);
         end
      end
      if (finish_req) begin
         for (int i = 0; i < 3; i++) begin
            check("bits_pending", i, exp_bits[i].size(), 0);
            check("done_pending", i, exp_done[i].size(), 0);
         end
         check("checks_pending", 0, chk_q.size(), 0);
         $display("%0d/%0d checks passed", n_pass, n_chk);
         $finish;
      end
   end

   task automatic push_chk(input int at, input int d, input int s, input int e, input int a);
      chk_q.push_back('{at, d, s, e, a});
   endtask

   task automatic expect_lvl(input int at, input int d, input int s, input int e);
      push_chk(at, d, s, e, 0);
   endtask

   // Presents a word, waits (bounded) for the handshake and loads the scoreboard.
   // e = cycle number seen at the negedge of the first bit cycle.
   task automatic send(input int d, input logic [7:0] w, input bit hold, output int e);
      int t = 0;
      @(negedge clk);
      din[d] = w;
      dv[d]  = 1'b1;
      while (rdy[d] !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) push_chk(cyc + 1, d, SigTimeout, 0, 1);
      e = cyc + 1;
      for (int k = 7; k >= 0; k--) repeat (div_of[d]) exp_bits[d].push_back(w[k]);
      exp_done[d].push_back(e + 8 * div_of[d]);
      @(posedge clk);
      #1;
      if (!hold) dv[d] = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int e, e1, e2;
      for (int i = 0; i < 3; i++) begin
         dv[i]  = 1'b0;
         din[i] = 8'h00;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         expect_lvl(cyc + 1, d, SigReady, 1);
         expect_lvl(cyc + 1, d, SigBusy, 0);
         expect_lvl(cyc + 1, d, SigValid, 0);
         expect_lvl(cyc + 1, d, SigBit, 0);
         expect_lvl(cyc + 1, d, SigDone, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic word 1100_1010.
      send(0, 8'hCA, 1'b0, e);
      expect_lvl(e + 7, 0, SigReady, 0);
      expect_lvl(e + 7, 0, SigBusy, 1);
      expect_lvl(e + 8, 0, SigValid, 0);
      expect_lvl(e + 8, 0, SigReady, 1);
      expect_lvl(e + 8, 0, SigBusy, 0);
      wait_until(e + 10);

      // Divide-by-3: 24 busy cycles, done right after.
      send(1, 8'hA5, 1'b0, e);
      for (int k = 0; k < 24; k++) expect_lvl(e + k, 1, SigBusy, 1);
      expect_lvl(e + 24, 1, SigBusy, 0);
      expect_lvl(e + 24, 1, SigReady, 1);
      wait_until(e + 26);

      // Back-to-back with GAP=2 and data_valid held high.
      send(2, 8'hF0, 1'b1, e1);
      for (int k = 8; k < 10; k++) begin
         expect_lvl(e1 + k, 2, SigValid, 0);
         expect_lvl(e1 + k, 2, SigBit, 0);
         expect_lvl(e1 + k, 2, SigBusy, 1);
         expect_lvl(e1 + k, 2, SigReady, 0);
      end
      expect_lvl(e1 + 10, 2, SigReady, 1);
      send(2, 8'h0F, 1'b0, e2);
      push_chk(e2, 2, SigSpacing, 11, e2 - e1);
      wait_until(e2 + 12);

      // Toggle inputs mid-word; nothing may be taken while data_ready=0.
      send(0, 8'h3C, 1'b0, e);
      for (int k = 0; k < 8; k++) expect_lvl(e + k, 0, SigReady, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         dv[0]  = (i % 2 == 1);
         din[0] = 8'($urandom);
      end
      @(negedge clk);
      dv[0] = 1'b0;
      expect_lvl(cyc + 1, 0, SigReady, 1);
      send(0, 8'h81, 1'b0, e);
      wait_until(e + 10);

      // Detector loopback: F0 has no "1011", 0101_1001 matches at bit 4.
      send(0, 8'hF0, 1'b0, e);
      for (int k = 0; k < 9; k++) expect_lvl(e + k, 0, SigDet, 0);
      wait_until(e + 10);
      send(0, 8'h59, 1'b0, e);
      expect_lvl(e + 4, 0, SigDet, 0);
      expect_lvl(e + 5, 0, SigDet, 1);
      expect_lvl(e + 6, 0, SigDet, 0);
      wait_until(e + 10);

      // Reset during the 4th bit of 8'hFF.
      send(0, 8'hFF, 1'b0, e);
      wait_until(e + 3);
      rst_n = 1'b0;
      expect_lvl(e + 4, 0, SigValid, 0);
      expect_lvl(e + 4, 0, SigBit, 0);
      expect_lvl(e + 4, 0, SigBusy, 0);
      expect_lvl(e + 4, 0, SigReady, 1);
      for (int k = 4; k < 11; k++) expect_lvl(e + k, 0, SigDone, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_bits[0].delete();
      exp_done[0].delete();
      send(0, 8'h96, 1'b0, e);
      wait_until(e + 12);

      finish_req = 1'b1;
      repeat (4) @(negedge clk);
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bit_stream_gen.md
# bit_stream_gen

Serial bit-stream generator that turns parallel words into a timed MSB-first bit sequence. It sits upstream of the Moore sequence-detector FSMs and drives their single-bit serial input. Words are accepted over a valid/ready handshake. Each bit is held for a programmable number of clocks, and an idle gap separates consecutive words.

## Interface
- WIDTH, 8: bits per word (≥2).
- CLK_DIV, 1: clocks each bit is held on bit_out (≥1).
- GAP, 0: idle clocks after a word's last bit before the next word may be accepted (≥0).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word this cycle.
- bit_out  out  1  serial bit; connects to a detector's bit_in.
- bit_valid  out  1  bit_out carries a word bit.
- busy  out  1  a word is in flight (SHIFT or GAP).
- done  out  1  one-cycle pulse after a word's last bit completes.

## Operation
- States: IDLE, SHIFT, GAP.
- Reset (rst_n=0 at a rising edge):
  - Next state is IDLE; shift register, bit counter and divider counter clear.
  - Outputs: data_ready=1, bit_out=0, bit_valid=0, busy=0, done=0.
- IDLE:
  - data_ready=1, bit_out=0, bit_valid=0, busy=0.
  - On data_valid&&data_ready at an edge: capture data_in into the shift register, load bit counter=WIDTH-1 and divider=CLK_DIV-1, go to SHIFT.
  - data_in is don't-care when data_valid=0.
- SHIFT:
  - data_ready=0, busy=1, bit_valid=1, bit_out=shift register MSB.
  - Divider decrements each clock.
  - At divider=0 and bit counter>0: shift left by one, decrement bit counter, reload divider.
  - At divider=0 and bit counter=0: assert done next cycle. If GAP>0, go to GAP with gap counter=GAP-1; if GAP=0, go to IDLE.
- GAP:
  - data_ready=0, busy=1, bit_valid=0, bit_out=0.
  - Gap counter decrements each clock; at 0, go to IDLE.
- done:
  - Registered; high for exactly one cycle.
  - That cycle is the first cycle after the last bit period (first GAP cycle, or first IDLE cycle when GAP=0).
- data_valid is ignored while data_ready=0. No word is queued and the upstream must hold it.
- Counter widths: bit counter ceil(log2(WIDTH)), divider ceil(log2(CLK_DIV)) with a minimum of 1, gap counter ceil(log2(GAP)) with a minimum of 1. No overflow is possible.

## Timing
- Latency: handshake at edge N puts the MSB on bit_out from edge N+1 (bit_valid=1).
- Bit k (k=0 is the MSB) is valid during cycles N+1+k·CLK_DIV through N+(k+1)·CLK_DIV.
- Last bit ends at cycle N+WIDTH·CLK_DIV.
- done is high in cycle N+WIDTH·CLK_DIV+1.
- data_ready returns high in cycle N+WIDTH·CLK_DIV+1+GAP.
- Throughput: one word per WIDTH·CLK_DIV+GAP+1 clocks. The minimum is one IDLE cycle between words even with GAP=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from data_valid or data_in to any output.
- Reset mid-word: at the first edge with rst_n=0, the word is discarded, no done pulse occurs, and all outputs take their reset values the following cycle.
- Reset has priority over a simultaneous handshake.

## Test plan
- Basic word (WIDTH=8, CLK_DIV=1, GAP=0): after reset, send 8'b1100_1010.
  - Required: bit_out=1,1,0,0,1,0,1,0 on the 8 cycles after the handshake, bit_valid=1 for exactly those 8 cycles.
  - Required: done high on cycle 9, data_ready high on cycle 9.
- Clock divider (CLK_DIV=3): send 8'hA5.
  - Required: each bit held exactly 3 cycles (1,1,1,0,0,0,1,1,1,…).
  - Required: done at handshake+25, busy high for 24 cycles.
- Gap and back-to-back (GAP=2): data_valid held high with words 8'hF0 then 8'h0F.
  - Required: second handshake occurs exactly 11 cycles after the first.
  - Required: 2 GAP cycles with bit_valid=0 and bit_out=0; the second word's bits are 0,0,0,0,1,1,1,1.
- Handshake blocking: toggle data_valid and data_in during SHIFT.
  - Required: data_ready=0 throughout and the transmitted bits are unchanged.
  - Required: a new word is accepted only when data_ready=1.
- Reset mid-operation: assert rst_n=0 for one cycle at the 4th bit of 8'hFF.
  - Required: next cycle bit_valid=0, bit_out=0, busy=0, data_ready=1, and no done pulse.
  - Required: a subsequent word transmits normally.
- Detector loopback: connect bit_out to a Moore detector's bit_in (bit_valid used as qualifier) and transmit a word containing the target pattern.
  - Required: the detector's out asserts on the expected cycle; a word without the pattern never asserts it.
